// File: rtl/video_pixel_fx.sv
// Per-pixel RGB colour effect stage with a frame-synchronous mode switch.
// Data, hsync, vsync and VDE pass through a fixed two-register pipeline.
module video_pixel_fx #(
   parameter int CW         = 8,
   parameter int THRESH     = 128,
   parameter int POST_BITS  = 3,
   parameter int FLASH_LOG2 = 5
) (
   input  logic              clk,
   input  logic              n_rst,
   input  logic [3*CW-1:0]   i_vid_data,
   input  logic              i_vid_hsync,
   input  logic              i_vid_vsync,
   input  logic              i_vid_VDE,
   input  logic [3:0]        sw,
   output logic [3*CW-1:0]   o_vid_data,
   output logic              o_vid_hsync,
   output logic              o_vid_vsync,
   output logic              o_vid_VDE,
   output logic [2:0]        o_mode
);

   localparam logic [2:0] MODE_PASS   = 3'd0;
   localparam logic [2:0] MODE_INVERT = 3'd1;
   localparam logic [2:0] MODE_GRAY   = 3'd2;
   localparam logic [2:0] MODE_THRESH = 3'd3;
   localparam logic [2:0] MODE_POST   = 3'd4;
   localparam logic [2:0] MODE_ROTATE = 3'd5;
   localparam logic [2:0] MODE_FLASH  = 3'd7;

   localparam logic [CW-1:0] THRESH_C  = THRESH[CW-1:0];
   localparam logic [CW-1:0] POST_MASK = {CW{1'b1}} << (CW - POST_BITS);

   logic                  r_vsync_prev;
   logic [FLASH_LOG2-1:0] r_frame_cnt;
   logic [2:0]            r_active_mode;

   logic [CW-1:0]         r_s1_r, r_s1_g, r_s1_b, r_s1_y;
   logic [2:0]            r_s1_mode;
   logic                  r_s1_flash, r_s1_hsync, r_s1_vsync, r_s1_vde;

   logic                  w_vs_rise;
   logic [CW-1:0]         w_in_r, w_in_g, w_in_b, w_y;
   logic [CW+1:0]         w_sum;
   logic [3*CW-1:0]       w_fx;

   assign w_vs_rise = i_vid_vsync & ~r_vsync_prev;
   assign w_in_r    = i_vid_data[3*CW-1:2*CW];
   assign w_in_g    = i_vid_data[2*CW-1:CW];
   assign w_in_b    = i_vid_data[CW-1:0];
   assign w_sum     = {2'b00, w_in_r} + {1'b0, w_in_g, 1'b0} + {2'b00, w_in_b};
   assign w_y       = CW'(w_sum >> 2);
   assign o_mode    = r_active_mode;

   // Mode and frame counter only move on the vsync rising edge so a frame never tears.
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         r_vsync_prev  <= 1'b0;
         r_frame_cnt   <= '0;
         r_active_mode <= MODE_PASS;
      end else begin
         r_vsync_prev <= i_vid_vsync;
         if (w_vs_rise) begin
            r_frame_cnt <= r_frame_cnt + 1'b1;
            if (!sw[3]) r_active_mode <= sw[2:0];
         end
      end
   end

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         r_s1_r     <= '0;
         r_s1_g     <= '0;
         r_s1_b     <= '0;
         r_s1_y     <= '0;
         r_s1_mode  <= MODE_PASS;
         r_s1_flash <= 1'b0;
         r_s1_hsync <= 1'b0;
         r_s1_vsync <= 1'b0;
         r_s1_vde   <= 1'b0;
      end else begin
         r_s1_r     <= w_in_r;
         r_s1_g     <= w_in_g;
         r_s1_b     <= w_in_b;
         r_s1_y     <= w_y;
         r_s1_mode  <= r_active_mode;
         r_s1_flash <= r_frame_cnt[FLASH_LOG2-1];
         r_s1_hsync <= i_vid_hsync;
         r_s1_vsync <= i_vid_vsync;
         r_s1_vde   <= i_vid_VDE;
      end
   end

   always_comb begin
      w_fx = {r_s1_r, r_s1_g, r_s1_b};
      case (r_s1_mode)
         MODE_INVERT: w_fx = ~{r_s1_r, r_s1_g, r_s1_b};
         MODE_GRAY:   w_fx = {r_s1_y, r_s1_y, r_s1_y};
         MODE_THRESH: w_fx = (r_s1_y >= THRESH_C) ? {3*CW{1'b1}} : '0;
         MODE_POST:   w_fx = {r_s1_r & POST_MASK, r_s1_g & POST_MASK, r_s1_b & POST_MASK};
         MODE_ROTATE: w_fx = {r_s1_g, r_s1_b, r_s1_r};
         MODE_FLASH:  if (r_s1_flash) w_fx = ~{r_s1_r, r_s1_g, r_s1_b};
         default:     w_fx = {r_s1_r, r_s1_g, r_s1_b};
      endcase
      if (!r_s1_vde) w_fx = '0;
   end

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         o_vid_data  <= '0;
         o_vid_hsync <= 1'b0;
         o_vid_vsync <= 1'b0;
         o_vid_VDE   <= 1'b0;
      end else begin
         o_vid_data  <= w_fx;
         o_vid_hsync <= r_s1_hsync;
         o_vid_vsync <= r_s1_vsync;
         o_vid_VDE   <= r_s1_vde;
      end
   end

endmodule

// File: tb/tb_video_pixel_fx.sv
// Directed bench for video_pixel_fx: latency, frame-synchronous mode switch,
// every effect mode, freeze, blanking, flash phase and mid-frame reset.
module tb_video_pixel_fx;

   logic        clk;
   logic        n_rst;
   logic [23:0] vid_data;
   logic        vid_hsync, vid_vsync, vid_vde;
   logic [3:0]  sw;
   logic [23:0] o_vid_data;
   logic        o_vid_hsync, o_vid_vsync, o_vid_VDE;
   logic [2:0]  o_mode;

   int checks   = 0;
   int failures = 0;
   int fcnt     = 0;

   video_pixel_fx #(.CW(8), .THRESH(128), .POST_BITS(3), .FLASH_LOG2(5)) dut (
      .clk         (clk),
      .n_rst       (n_rst),
      .i_vid_data  (vid_data),
      .i_vid_hsync (vid_hsync),
      .i_vid_vsync (vid_vsync),
      .i_vid_VDE   (vid_vde),
      .sw          (sw),
      .o_vid_data  (o_vid_data),
      .o_vid_hsync (o_vid_hsync),
      .o_vid_vsync (o_vid_vsync),
      .o_vid_VDE   (o_vid_VDE),
      .o_mode      (o_mode)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_pixel(input logic [23:0] d, input logic vde);
      vid_data = d;
      vid_vde  = vde;
   endtask

   // One-cycle vsync pulse; the mode register must update right after the edge.
   task automatic vs_pulse(input logic [2:0] exp_mode);
      vid_vsync = 1'b1;
      step();
      fcnt++;
      check_eq("o_mode_after_edge", {29'd0, o_mode}, {29'd0, exp_mode});
      vid_vsync = 1'b0;
   endtask

   task automatic pixel_check(input string tag, input logic [23:0] d, input logic [23:0] exp);
      drive_pixel(d, 1'b1);
      step();
      step();
      check_eq(tag, {8'd0, o_vid_data}, {8'd0, exp});
   endtask

   initial begin
      n_rst     = 1'b0;
      sw        = 4'b0000;
      vid_hsync = 1'b1;
      vid_vsync = 1'b0;
      drive_pixel(24'hABCDEF, 1'b1);
      step();
      step();
      check_eq("rst_data",  {8'd0, o_vid_data}, 32'd0);
      check_eq("rst_hsync", {31'd0, o_vid_hsync}, 32'd0);
      check_eq("rst_vsync", {31'd0, o_vid_vsync}, 32'd0);
      check_eq("rst_vde",   {31'd0, o_vid_VDE}, 32'd0);
      check_eq("rst_mode",  {29'd0, o_mode}, 32'd0);

      // latency: output must not appear early and must land exactly 2 cycles later
      n_rst     = 1'b1;
      vid_hsync = 1'b0;
      drive_pixel(24'h000000, 1'b0);
      step();
      step();
      drive_pixel(24'h123456, 1'b1);
      vid_hsync = 1'b1;
      vid_vsync = 1'b1;
      fcnt++;
      step();
      check_eq("lat_not_early", {8'd0, o_vid_data}, 32'd0);
      check_eq("lat_vde_not_early", {31'd0, o_vid_VDE}, 32'd0);
      step();
      check_eq("lat_data",  {8'd0, o_vid_data}, 32'h123456);
      check_eq("lat_vde",   {31'd0, o_vid_VDE}, 32'd1);
      check_eq("lat_hsync", {31'd0, o_vid_hsync}, 32'd1);
      check_eq("lat_vsync", {31'd0, o_vid_vsync}, 32'd1);
      vid_vsync = 1'b0;
      vid_hsync = 1'b0;

      // switch change mid-frame has no effect until the next vsync edge
      sw = 4'b0001;
      pixel_check("midframe_pass", 24'h00FF80, 24'h00FF80);
      check_eq("midframe_mode", {29'd0, o_mode}, 32'd0);
      vs_pulse(3'd1);
      step();
      check_eq("edge_pixel_old_mode", {8'd0, o_vid_data}, 32'h00FF80);
      step();
      check_eq("invert_new_mode", {8'd0, o_vid_data}, 32'hFF007F);

      sw = 4'b0010; vs_pulse(3'd2);
      pixel_check("gray_204060", 24'h204060, 24'h404040);
      sw = 4'b0011; vs_pulse(3'd3);
      pixel_check("thresh_204060", 24'h204060, 24'h000000);
      pixel_check("thresh_F0F0F0", 24'hF0F0F0, 24'hFFFFFF);
      pixel_check("thresh_eq_128", 24'h808080, 24'hFFFFFF);
      pixel_check("thresh_127", 24'h7F7F7F, 24'h000000);
      sw = 4'b0100; vs_pulse(3'd4);
      pixel_check("post_204060", 24'h204060, 24'h204060);
      pixel_check("post_F0F0F0", 24'hF0F0F0, 24'hE0E0E0);
      pixel_check("post_1F3F5F", 24'h1F3F5F, 24'h002040);
      sw = 4'b0110; vs_pulse(3'd6);
      pixel_check("reserved_pass", 24'h204060, 24'h204060);
      sw = 4'b0101; vs_pulse(3'd5);
      pixel_check("rotate_204060", 24'h204060, 24'h406020);

      // freeze holds the rotate mode across an edge
      sw = 4'b1010; vs_pulse(3'd5);
      pixel_check("freeze_rotate", 24'h204060, 24'h406020);

      drive_pixel(24'hFFFFFF, 1'b0);
      step();
      step();
      check_eq("blank_data", {8'd0, o_vid_data}, 32'd0);
      check_eq("blank_vde",  {31'd0, o_vid_VDE}, 32'd0);

      // flash: phase is bit 4 of the frame count, covering a wrap of the counter
      sw = 4'b0111; vs_pulse(3'd7);
      for (int i = 0; i < 32; i++) begin
         pixel_check($sformatf("flash_frame%0d", fcnt % 32), 24'h00FF80,
                     ((fcnt % 32) >= 16) ? 24'hFF007F : 24'h00FF80);
         vs_pulse(3'd7);
      end

      // asynchronous reset mid-frame flushes immediately, mode stays 0 afterwards
      drive_pixel(24'h00FF80, 1'b1);
      step();
      n_rst = 1'b0;
      #1;
      check_eq("midrst_data", {8'd0, o_vid_data}, 32'd0);
      check_eq("midrst_vde",  {31'd0, o_vid_VDE}, 32'd0);
      check_eq("midrst_mode", {29'd0, o_mode}, 32'd0);
      step();
      n_rst = 1'b1;
      sw = 4'b0001;
      pixel_check("post_rst_pass", 24'h00FF80, 24'h00FF80);
      check_eq("post_rst_mode", {29'd0, o_mode}, 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
